// File: rtl/temporizador_lapsos_if.sv
// rtl/temporizador_lapsos_if.sv - controller/lapse-timer handshake interface
interface temporizador_lapsos_if #(
  parameter int TW = 3
) ();
  logic          activar;
  logic          detener;
  logic          ocupado;
  logic          fin_lapso;
  logic [TW-1:0] ticks_restantes;

  modport master (
    output activar,
    output detener,
    input  ocupado,
    input  fin_lapso,
    input  ticks_restantes
  );

  modport slave (
    input  activar,
    input  detener,
    output ocupado,
    output fin_lapso,
    output ticks_restantes
  );
endinterface

// File: rtl/temporizador_lapsos.sv
// rtl/temporizador_lapsos.sv - lapse timer, PRESCALER*N_TICKS clocks per lapse; TIMER_AUTORECARGA_EN selects periodic reload
module temporizador_lapsos #(
  parameter int PRESCALER = 50_000_000,
  parameter int N_TICKS   = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  temporizador_lapsos_if.slave  bus
);

  localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam int TW = $clog2(N_TICKS + 1);

  localparam logic [PW-1:0] PRE_FIN   = PW'(PRESCALER - 1);
  localparam logic [TW-1:0] TICK_FIN  = TW'(N_TICKS - 1);
  localparam logic [TW-1:0] TICKS_TOT = TW'(N_TICKS);

  typedef enum logic {
    E_REPOSO   = 1'b0,
    E_CONTANDO = 1'b1
  } estado_t;

  estado_t       state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          ocupado_q, ocupado_d;
  logic          fin_q, fin_d;

  // State and counter registers; reset aborts any lapse without a fin pulse
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= E_REPOSO;
      pre_cnt_q  <= '0;
      tick_cnt_q <= '0;
      ocupado_q  <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      ocupado_q  <= ocupado_d;
      fin_q      <= fin_d;
    end
  end

  // Next state: detener beats activar, activar beats normal counting
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    tick_cnt_d = tick_cnt_q;
    fin_d      = 1'b0;

    case (state_q)
      E_REPOSO: begin
        if (bus.activar && !bus.detener) begin
          state_d    = E_CONTANDO;
          pre_cnt_d  = '0;
          tick_cnt_d = '0;
        end
      end

      E_CONTANDO: begin
        if (bus.detener) begin
          state_d    = E_REPOSO;
          pre_cnt_d  = '0;
          tick_cnt_d = '0;
        end else if (bus.activar) begin
          // Retrigger restarts the lapse, even on what would be the final edge
          pre_cnt_d  = '0;
          tick_cnt_d = '0;
        end else if (pre_cnt_q == PRE_FIN) begin
          pre_cnt_d = '0;
          if (tick_cnt_q == TICK_FIN) begin
            tick_cnt_d = '0;
            fin_d      = 1'b1;
`ifdef TIMER_AUTORECARGA_EN
            state_d    = E_CONTANDO;
`else
            state_d    = E_REPOSO;
`endif
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end else begin
          pre_cnt_d = pre_cnt_q + PW'(1);
        end
      end

      default: begin
        state_d    = E_REPOSO;
        pre_cnt_d  = '0;
        tick_cnt_d = '0;
      end
    endcase

    ocupado_d = (state_d == E_CONTANDO);
  end

  assign bus.ocupado         = ocupado_q;
  assign bus.fin_lapso       = fin_q;
  assign bus.ticks_restantes = (state_q == E_CONTANDO) ? (TICKS_TOT - tick_cnt_q) : '0;

endmodule

// File: tb/tb_temporizador_lapsos.sv
// tb/tb_temporizador_lapsos.sv - directed self-checking bench for temporizador_lapsos
module tb_temporizador_lapsos;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  temporizador_lapsos_if #(.TW(2)) bus_a ();
  temporizador_lapsos_if #(.TW(2)) bus_b ();

  temporizador_lapsos #(.PRESCALER(4), .N_TICKS(3)) u_dut_a (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_a)
  );

  temporizador_lapsos #(.PRESCALER(1), .N_TICKS(2)) u_dut_b (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic ocu, input logic fin, input logic [1:0] tr);
    chk({tag, ".ocupado"}, 32'(bus_a.ocupado), 32'(ocu));
    chk({tag, ".fin"}, 32'(bus_a.fin_lapso), 32'(fin));
    chk({tag, ".ticks"}, 32'(bus_a.ticks_restantes), 32'(tr));
  endtask

  task automatic chk_b(input string tag, input logic ocu, input logic fin, input logic [1:0] tr);
    chk({tag, ".ocupado"}, 32'(bus_b.ocupado), 32'(ocu));
    chk({tag, ".fin"}, 32'(bus_b.fin_lapso), 32'(fin));
    chk({tag, ".ticks"}, 32'(bus_b.ticks_restantes), 32'(tr));
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    bus_a.activar   = 1'b1;
    bus_a.detener   = 1'b0;
    bus_b.activar   = 1'b1;
    bus_b.detener   = 1'b0;

    // 1: reset held 3 cycles with activar high
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("t1_reset", 1'b0, 1'b0, 2'd0);
      chk_b("t1_reset_b", 1'b0, 1'b0, 2'd0);
    end
    reset         = 1'b0;
    bus_a.activar = 1'b0;
    bus_b.activar = 1'b0;
    step();
    chk_a("t1_idle", 1'b0, 1'b0, 2'd0);

    // 2: basic lapse, edge k = arm
    bus_a.activar = 1'b1;
    step();
    bus_a.activar = 1'b0;
    chk_a("t2_arm", 1'b1, 1'b0, 2'd3);
    for (int i = 1; i < 12; i++) begin
      step();
      chk_a("t2_count", 1'b1, 1'b0, 2'(3 - i / 4));
    end
    step();
    chk_a("t2_fin", 1'b0, 1'b1, 2'd0);
    step();
    chk_a("t2_after", 1'b0, 1'b0, 2'd0);

    // 3: retrigger at k+6, single fin at k+18
    bus_a.activar = 1'b1;
    step();
    bus_a.activar = 1'b0;
    for (int i = 1; i < 6; i++) step();
    chk_a("t3_pre", 1'b1, 1'b0, 2'd2);
    bus_a.activar = 1'b1;
    step();
    bus_a.activar = 1'b0;
    chk_a("t3_retrig", 1'b1, 1'b0, 2'd3);
    for (int i = 7; i < 18; i++) begin
      step();
      chk("t3_nofin", 32'(bus_a.fin_lapso), 32'd0);
    end
    step();
    chk_a("t3_fin", 1'b0, 1'b1, 2'd0);
    step();
    chk_a("t3_after", 1'b0, 1'b0, 2'd0);

    // 4: abort at k+5, then detener+activar together in idle
    bus_a.activar = 1'b1;
    step();
    bus_a.activar = 1'b0;
    for (int i = 1; i < 5; i++) step();
    bus_a.detener = 1'b1;
    step();
    bus_a.detener = 1'b0;
    chk_a("t4_abort", 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t4_nofin", 32'(bus_a.fin_lapso), 32'd0);
    end
    bus_a.activar = 1'b1;
    bus_a.detener = 1'b1;
    step();
    bus_a.activar = 1'b0;
    bus_a.detener = 1'b0;
    chk_a("t4_both_idle", 1'b0, 1'b0, 2'd0);

    // 5a: detener on the final edge suppresses fin
    bus_a.activar = 1'b1;
    step();
    bus_a.activar = 1'b0;
    for (int i = 1; i < 12; i++) step();
    chk_a("t5_last", 1'b1, 1'b0, 2'd1);
    bus_a.detener = 1'b1;
    step();
    bus_a.detener = 1'b0;
    chk_a("t5_det_final", 1'b0, 1'b0, 2'd0);

    // 5b: activar in the fin cycle starts a new lapse
    bus_a.activar = 1'b1;
    step();
    bus_a.activar = 1'b0;
    for (int i = 1; i < 12; i++) step();
    step();
    chk_a("t5_fin1", 1'b0, 1'b1, 2'd0);
    bus_a.activar = 1'b1;
    step();
    bus_a.activar = 1'b0;
    chk_a("t5_rearm", 1'b1, 1'b0, 2'd3);
    for (int i = 1; i < 12; i++) step();
    step();
    chk_a("t5_fin2", 1'b0, 1'b1, 2'd0);

    // 5c: retrigger on the final edge suppresses fin
    bus_a.activar = 1'b1;
    step();
    for (int i = 0; i < 1; i++) bus_a.activar = 1'b0;
    for (int i = 1; i < 12; i++) step();
    bus_a.activar = 1'b1;
    step();
    bus_a.activar = 1'b0;
    chk_a("t5_retrig_final", 1'b1, 1'b0, 2'd3);
    for (int i = 1; i < 12; i++) step();
    step();
    chk_a("t5_fin3", 1'b0, 1'b1, 2'd0);

    // 6: PRESCALER=1, N_TICKS=2
    bus_b.activar = 1'b1;
    step();
    bus_b.activar = 1'b0;
    chk_b("t6_arm", 1'b1, 1'b0, 2'd2);
    step();
    chk_b("t6_k1", 1'b1, 1'b0, 2'd1);
    step();
`ifdef TIMER_AUTORECARGA_EN
    chk_b("t6_fin1", 1'b1, 1'b1, 2'd2);
    step();
    chk_b("t6_k3", 1'b1, 1'b0, 2'd1);
    step();
    chk_b("t6_fin2", 1'b1, 1'b1, 2'd2);
    bus_b.detener = 1'b1;
    step();
    bus_b.detener = 1'b0;
    chk_b("t6_stop", 1'b0, 1'b0, 2'd0);
    step();
    chk_b("t6_idle", 1'b0, 1'b0, 2'd0);
`else
    chk_b("t6_fin", 1'b0, 1'b1, 2'd0);
    step();
    chk_b("t6_idle1", 1'b0, 1'b0, 2'd0);
    step();
    chk_b("t6_idle2", 1'b0, 1'b0, 2'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
